// File: rtl/reg_bank_pkg.sv
// Shared constants and types for the GPR bank: CPU-wide word/GPR defaults and
// the per-entry control bundle driven by the address decode.
package reg_bank_pkg;

    localparam int WORD_W  = 16;
    localparam int NUM_GPR = 8;

    typedef struct packed {
        logic we;     // load data
        logic bset;   // new producer issued
        logic bclr;   // producer wrote back
        logic flush;  // drop all outstanding producers
    } cell_ctl_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Register-bank port bundle: write port, two read ports and the busy scoreboard.
interface reg_bank_if
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int NREG  = NUM_GPR
);
    localparam int AW = addr_w(NREG);

    logic             LD_REG;
    logic [AW-1:0]    DR;
    logic [WIDTH-1:0] Din;
    logic [AW-1:0]    SR1;
    logic [AW-1:0]    SR2;
    logic [WIDTH-1:0] SR1_OUT;
    logic [WIDTH-1:0] SR2_OUT;
    logic             Mark;
    logic [AW-1:0]    MarkReg;
    logic             Clear;
    logic [NREG-1:0]  Busy;
    logic             SR1_Busy;
    logic             SR2_Busy;

    modport master (
        output LD_REG, DR, Din, SR1, SR2, Mark, MarkReg, Clear,
        input  SR1_OUT, SR2_OUT, Busy, SR1_Busy, SR2_Busy
    );

    modport slave (
        input  LD_REG, DR, Din, SR1, SR2, Mark, MarkReg, Clear,
        output SR1_OUT, SR2_OUT, Busy, SR1_Busy, SR2_Busy
    );

endinterface

// File: rtl/reg_bank_cell.sv
// One register-bank entry: WIDTH data bits plus the busy bit of its scoreboard slot.
module reg_bank_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  cell_ctl_t        ctl_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;

    // A mark in the same cycle as a write-back or flush means a newer producer
    // now owns this register, so set beats clear.
    always_comb begin
        data_d = ctl_i.we ? din_i : data_q;
        busy_d = busy_q;
        if (ctl_i.flush || ctl_i.bclr) busy_d = 1'b0;
        if (ctl_i.bset)                busy_d = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data_o = data_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/reg_bank.sv
// General-purpose register bank: NREG entries, one write port, two combinational
// read ports with optional write-to-read forwarding, and a busy scoreboard.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH  = WORD_W,
    parameter int NREG   = NUM_GPR,
    parameter int BYPASS = 1
) (
    input  logic     Clk,
    input  logic     Reset,
    reg_bank_if.slave bus
);

    localparam int AW  = addr_w(NREG);
    localparam bit BYP = (BYPASS != 0);

    logic [NREG-1:0][WIDTH-1:0] data;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            we_vec;

    // Out-of-range addresses match no entry, so writes and marks to them vanish.
    for (genvar i = 0; i < NREG; i++) begin : g_cell
        cell_ctl_t ctl;

        assign we_vec[i]  = bus.LD_REG && (bus.DR == AW'(i));
        assign ctl.we     = we_vec[i];
        assign ctl.bclr   = we_vec[i];
        assign ctl.bset   = bus.Mark && (bus.MarkReg == AW'(i));
        assign ctl.flush  = bus.Clear;

        reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
            .Clk    (Clk),
            .Reset  (Reset),
            .ctl_i  (ctl),
            .din_i  (bus.Din),
            .data_o (data[i]),
            .busy_o (busy[i])
        );
    end

    logic [WIDTH-1:0] rd1, rd2;
    logic             rb1, rb2;
    logic             wr_any, fwd1, fwd2;

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        rb1 = 1'b0;
        rb2 = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.SR1 == AW'(i)) begin
                rd1 = data[i];
                rb1 = busy[i];
            end
            if (bus.SR2 == AW'(i)) begin
                rd2 = data[i];
                rb2 = busy[i];
            end
        end
    end

    // wr_any already excludes out-of-range DR, so a forwarded read never
    // leaks Din onto an address that must read 0.
    assign wr_any = |we_vec;
    assign fwd1   = BYP && wr_any && (bus.DR == bus.SR1);
    assign fwd2   = BYP && wr_any && (bus.DR == bus.SR2);

    assign bus.SR1_OUT  = fwd1 ? bus.Din : rd1;
    assign bus.SR2_OUT  = fwd2 ? bus.Din : rd2;
    assign bus.SR1_Busy = rb1 & ~fwd1;
    assign bus.SR2_Busy = rb2 & ~fwd2;
    assign bus.Busy     = busy;

endmodule

// File: tb/tb_reg_bank.sv
// Randomized check of two reg_bank builds (8 regs with forwarding, 6 regs without)
// against an array-based reference model driven by the same stimulus.
module tb_reg_bank;

    logic        clk;
    logic        rst;
    logic        ld, mark, clr;
    logic [2:0]  dr, s1, s2, mr;
    logic [15:0] din;

    int n_tests;
    int n_fail;

    // model state: index 0 = 8-reg/bypass build, 1 = 6-reg/no-bypass build
    logic [15:0] mem [2][8];
    logic [7:0]  bz  [2];
    int          nr  [2] = '{8, 6};
    bit          bp  [2] = '{1'b1, 1'b0};

    reg_bank_if #(.WIDTH(16), .NREG(8)) ifa ();
    reg_bank_if #(.WIDTH(16), .NREG(6)) ifb ();

    reg_bank #(.WIDTH(16), .NREG(8), .BYPASS(1)) dut_a (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifa.slave)
    );

    reg_bank #(.WIDTH(16), .NREG(6), .BYPASS(0)) dut_b (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifb.slave)
    );

    assign ifa.LD_REG  = ld;   assign ifb.LD_REG  = ld;
    assign ifa.DR      = dr;   assign ifb.DR      = dr;
    assign ifa.Din     = din;  assign ifb.Din     = din;
    assign ifa.SR1     = s1;   assign ifb.SR1     = s1;
    assign ifa.SR2     = s2;   assign ifb.SR2     = s2;
    assign ifa.Mark    = mark; assign ifb.Mark    = mark;
    assign ifa.MarkReg = mr;   assign ifb.MarkReg = mr;
    assign ifa.Clear   = clr;  assign ifb.Clear   = clr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd(input int k, input int s);
        if (s >= nr[k]) return 16'h0;
        if (bp[k] && ld && int'(dr) == s) return din;
        return mem[k][s];
    endfunction

    function automatic logic exp_brd(input int k, input int s);
        if (s >= nr[k]) return 1'b0;
        if (bp[k] && ld && int'(dr) == s) return 1'b0;
        return bz[k][s];
    endfunction

    task automatic model_tick();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) mem[k][r] = 16'h0;
                bz[k] = 8'h0;
            end else begin
                if (ld && int'(dr) < nr[k]) mem[k][dr] = din;
                if (clr) bz[k] = 8'h0;
                else if (ld && int'(dr) < nr[k]) bz[k][dr] = 1'b0;
                if (mark && int'(mr) < nr[k]) bz[k][mr] = 1'b1;
            end
        end
    endtask

    // inputs are applied 1 time unit after posedge; check midway through the cycle
    task automatic settle();
        #4;
        chk("a_sr1",   32'(ifa.SR1_OUT),  32'(exp_rd(0, int'(s1))));
        chk("a_sr2",   32'(ifa.SR2_OUT),  32'(exp_rd(0, int'(s2))));
        chk("a_sr1b",  32'(ifa.SR1_Busy), 32'(exp_brd(0, int'(s1))));
        chk("a_sr2b",  32'(ifa.SR2_Busy), 32'(exp_brd(0, int'(s2))));
        chk("a_busy",  32'(ifa.Busy),     32'(bz[0]));
        chk("b_sr1",   32'(ifb.SR1_OUT),  32'(exp_rd(1, int'(s1))));
        chk("b_sr2",   32'(ifb.SR2_OUT),  32'(exp_rd(1, int'(s2))));
        chk("b_sr1b",  32'(ifb.SR1_Busy), 32'(exp_brd(1, int'(s1))));
        chk("b_sr2b",  32'(ifb.SR2_Busy), 32'(exp_brd(1, int'(s2))));
        chk("b_busy",  32'(ifb.Busy),     32'(bz[1] & 8'h3f));
    endtask

    task automatic tick();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; ld = 1'b0; mark = 1'b0; clr = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 8; r++) mem[k][r] = 16'h0;
            bz[k] = 8'h0;
        end
        idle();
        dr = 3'd0; s1 = 3'd0; s2 = 3'd0; mr = 3'd0; din = 16'h0;
        rst = 1'b1;
        tick();
        idle();

        // every register reads 0 after reset
        for (int i = 0; i < 8; i++) begin
            s1 = 3'(i);
            s2 = 3'(7 - i);
            settle();
            chk("rst_rd", 32'(ifa.SR1_OUT), 32'h0);
            tick();
        end

        // write R3 with SR1 watching it
        ld = 1'b1; dr = 3'd3; din = 16'hBEEF; s1 = 3'd3;
        settle();
        chk("byp_beef",   32'(ifa.SR1_OUT), 32'h0000BEEF);
        chk("nobyp_old",  32'(ifb.SR1_OUT), 32'h0);
        tick();
        idle();
        settle();
        chk("beef_a", 32'(ifa.SR1_OUT), 32'h0000BEEF);
        chk("beef_b", 32'(ifb.SR1_OUT), 32'h0000BEEF);
        tick();

        // mark R5, write it back two cycles later
        mark = 1'b1; mr = 3'd5; s2 = 3'd5;
        settle();
        tick();
        idle();
        settle();
        chk("busy5_c1", 32'(ifa.Busy[5]), 32'd1);
        tick();
        ld = 1'b1; dr = 3'd5; din = 16'h1234;
        settle();
        chk("busy5_c2",  32'(ifa.Busy[5]),  32'd1);
        chk("sr2b_fwd",  32'(ifa.SR2_Busy), 32'd0);
        chk("sr2b_nofw", 32'(ifb.SR2_Busy), 32'd1);
        tick();
        idle();
        settle();
        chk("busy5_done", 32'(ifa.Busy[5]), 32'd0);
        chk("r5_data",    32'(ifa.SR2_OUT), 32'h00001234);
        tick();

        // write and re-mark R2 together
        ld = 1'b1; dr = 3'd2; din = 16'hA5C3; mark = 1'b1; mr = 3'd2; s1 = 3'd2;
        settle();
        tick();
        idle();
        settle();
        chk("r2_data", 32'(ifa.SR1_OUT), 32'h0000A5C3);
        chk("r2_busy", 32'(ifa.Busy[2]), 32'd1);
        tick();

        // flush with a simultaneous mark of R7
        clr = 1'b1; mark = 1'b1; mr = 3'd7;
        settle();
        tick();
        idle();
        settle();
        chk("clr_mark7_a", 32'(ifa.Busy), 32'h80);
        chk("clr_mark7_b", 32'(ifb.Busy), 32'h0);
        tick();

        // reset discards a write issued in the same cycle
        rst = 1'b1; ld = 1'b1; dr = 3'd1; din = 16'hFFFF; s1 = 3'd1;
        settle();
        tick();
        idle();
        settle();
        chk("rst_wr_a", 32'(ifa.SR1_OUT), 32'h0);
        chk("rst_wr_b", 32'(ifb.SR1_OUT), 32'h0);
        tick();

        // out-of-range write/mark on the 6-entry build
        ld = 1'b1; dr = 3'd4; din = 16'h4444; mark = 1'b1; mr = 3'd0;
        settle();
        tick();
        ld = 1'b1; dr = 3'd7; din = 16'h5A5A; mark = 1'b1; mr = 3'd6; s1 = 3'd7; s2 = 3'd4;
        settle();
        chk("b_oor_rd", 32'(ifb.SR1_OUT), 32'h0);
        tick();
        idle();
        settle();
        chk("b_oor_rd2",  32'(ifb.SR1_OUT), 32'h0);
        chk("b_oor_keep", 32'(ifb.SR2_OUT), 32'h00004444);
        chk("b_oor_busy", 32'(ifb.Busy),    32'h01);
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            ld   = 1'($urandom_range(0, 1));
            dr   = 3'($urandom_range(0, 7));
            din  = 16'($urandom);
            s1   = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
            s2   = ($urandom_range(0, 7) == 0) ? s1 : 3'($urandom_range(0, 7));
            mark = ($urandom_range(0, 2) == 0);
            mr   = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
            clr  = ($urandom_range(0, 9) == 0);
            settle();
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
